// File: rtl/conv_out_collector_if.sv
// conv_out_collector_if: column input stream and row-major pixel output stream of the collector
interface conv_out_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_OUTPUT = 32,
  parameter int OUT_DIM = 10
);
  localparam int RW = $clog2(OUT_DIM);
  logic col_valid;
  logic col_ready;
  logic [OUT_DIM-1:0][CONV_OUTPUT-1:0] col_data;
  logic pix_valid;
  logic pix_ready;
  logic pix_last;
  logic signed [DATA_WIDTH-1:0] pix_data;
  logic [RW-1:0] pix_row;
  logic [RW-1:0] pix_col;
  modport master (
    output col_valid, col_data, pix_ready,
    input col_ready, pix_valid, pix_data, pix_row, pix_col, pix_last
  );
  modport slave (
    input col_valid, col_data, pix_ready,
    output col_ready, pix_valid, pix_data, pix_row, pix_col, pix_last
  );
endinterface

// File: rtl/conv_out_collector.sv
// conv_out_collector: captures conv column beats into a feature map and drains it as a row-major pixel stream
module conv_out_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_OUTPUT = 32,
  parameter int IMAGE_SIZE = 12,
  parameter int KERNEL_SIZE = 3,
  parameter int SHIFT = 0,
  parameter int RELU_EN = 1
) (
  input logic clk,
  input logic rst,
  input logic start,
  conv_out_collector_if.slave bus,
  output logic busy,
  output logic done
);
  localparam int OUT_DIM = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int CW = $clog2(OUT_DIM);
  localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);
  localparam logic signed [CONV_OUTPUT-1:0] MAX_V = {{(CONV_OUTPUT-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [CONV_OUTPUT-1:0] MIN_V = {{(CONV_OUTPUT-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col_cnt, row_cnt;
  logic [DATA_WIDTH-1:0] fmap [OUT_DIM][OUT_DIM];
  logic col_acc, pix_acc, col_end, row_end;
  function automatic logic [DATA_WIDTH-1:0] post(input logic signed [CONV_OUTPUT-1:0] x);
    logic signed [CONV_OUTPUT-1:0] v;
    v = x >>> SHIFT;
    v = (RELU_EN != 0 && v[CONV_OUTPUT-1]) ? '0 : v;
    v = v > MAX_V ? MAX_V : v < MIN_V ? MIN_V : v;
    return v[DATA_WIDTH-1:0];
  endfunction
  // col_cnt addresses the capture column in COLLECT and the output column in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state <= state_nx;
      col_cnt <= state == IDLE ? '0 : (col_acc || pix_acc) ? (col_end ? '0 : col_cnt + 1'b1) : col_cnt;
      row_cnt <= state == IDLE ? '0 : (pix_acc && col_end) ? (row_end ? '0 : row_cnt + 1'b1) : row_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (col_acc) for (int i = 0; i < OUT_DIM; i++) fmap[i][col_cnt] <= post(bus.col_data[i]);
  end
  always_comb begin
    state_nx = state == IDLE    ? (start ? COLLECT : IDLE) :
               state == COLLECT ? (col_acc && col_end ? DRAIN : COLLECT) :
               state == DRAIN   ? (pix_acc && col_end && row_end ? DONE : DRAIN) : IDLE;
  end
  always_comb begin
    bus.col_ready = state == COLLECT;
    bus.pix_valid = state == DRAIN;
    col_acc = bus.col_ready && bus.col_valid;
    pix_acc = bus.pix_valid && bus.pix_ready;
    col_end = col_cnt == LAST;
    row_end = row_cnt == LAST;
    bus.pix_last = bus.pix_valid && col_end && row_end;
    bus.pix_data = bus.pix_valid ? fmap[row_cnt][col_cnt] : '0;
    bus.pix_row = bus.pix_valid ? row_cnt : '0;
    bus.pix_col = bus.pix_valid ? col_cnt : '0;
    busy = state == COLLECT || state == DRAIN;
    done = state == DONE;
  end
endmodule

// File: doc/conv_out_collector.md
Name: conv_out_collector

Overview:
- Receiving end of the parallel convolution array's column stream.
- Each accepted beat carries one output column: one CONV_OUTPUT-wide result per parallel conv lane, with lane index = output row.
- Block post-processes each result (arithmetic shift, optional ReLU, saturation to DATA_WIDTH) and stores the full OUT_DIM x OUT_DIM feature map.
- It then drains the map as a row-major pixel stream with valid/ready handshake toward the next layer or the output buffer.

Parameters:
- DATA_WIDTH, 16, width of the stored/output pixel (signed).
- CONV_OUTPUT, 32, width of each incoming conv result (signed).
- IMAGE_SIZE, 12, input image dimension.
- KERNEL_SIZE, 3, kernel dimension. OUT_DIM = IMAGE_SIZE-KERNEL_SIZE+1 (localparam, default 10).
- SHIFT, 0, arithmetic right shift applied to each conv result before saturation.
- RELU_EN, 1, 1 = clamp negative results to 0 before storage.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  arm collection; sampled only in IDLE.
- col_valid  in  1  column beat valid.
- col_data  in  CONV_OUTPUT x [OUT_DIM-1:0]  signed results; index i = output row i.
- col_ready  out  1  block can accept a column.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_data  out  DATA_WIDTH  signed post-processed pixel.
- pix_row  out  $clog2(OUT_DIM)  row of current pixel.
- pix_col  out  $clog2(OUT_DIM)  column of current pixel.
- pix_last  out  1  high with final pixel (OUT_DIM-1, OUT_DIM-1).
- busy  out  1  high in COLLECT or DRAIN.
- done  out  1  one-cycle pulse after last pixel handshake.

Behaviour:
- Reset: state IDLE; col_ready, pix_valid, pix_last, busy, done = 0; pix_data, pix_row, pix_col = 0; column/row counters = 0.
- Reset is honoured in any state, including mid-COLLECT and mid-DRAIN. Buffer contents are not cleared.
- Storage is registered: OUT_DIM x OUT_DIM x DATA_WIDTH.
- Post-processing per lane, applied on capture:
  - v = col_data[i] >>> SHIFT (sign-preserving).
  - If RELU_EN and v < 0, v = 0.
  - Saturate v to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- State IDLE:
  - col_ready = 0, pix_valid = 0.
  - start = 1 -> COLLECT next cycle; column counter cleared.
- State COLLECT:
  - col_ready = 1 combinationally from state.
  - Handshake: col_valid && col_ready stores all lanes into column col_cnt, then col_cnt++.
  - col_valid low inserts bubbles with no state change.
  - Handshake with col_cnt == OUT_DIM-1 -> DRAIN next cycle; col_ready drops that same next cycle.
- State DRAIN:
  - col_ready = 0; col_valid is ignored (no storage write).
  - pix_valid = 1 from the first DRAIN cycle; pixel (0,0) is presented in the cycle after the last column handshake (1-cycle latency).
  - pix_data = buffer[row][col], ordered row-major (col fastest).
  - pix_data, pix_row, pix_col hold stable while pix_valid && !pix_ready.
  - Each pix_valid && pix_ready handshake advances to the next pixel the following cycle. No gaps when pix_ready is held high: one pixel per cycle, OUT_DIM^2 cycles total.
  - pix_last is high only while presenting (OUT_DIM-1, OUT_DIM-1).
  - Handshake on the last pixel -> DONE; pix_valid = 0 next cycle.
- State DONE: done = 1 for exactly one cycle; -> IDLE.
- start outside IDLE is ignored. start held high through DONE re-arms in the following IDLE cycle (a new frame may begin 2 cycles after the last pixel).
- busy = (state == COLLECT || state == DRAIN).
- Counters wrap to 0 at OUT_DIM-1 (row and col). Nothing beyond OUT_DIM^2 pixels is emitted.

Test Plan:
- Basic frame: defaults, start, 10 back-to-back columns with col_data[i] = 100*c + i, pix_ready = 1 -> 100 pixels. Pixel (r,c) = 100*c + r, row-major order. pix_last on the 100th pixel. done pulses one cycle later. The first pix_valid appears the cycle after the 10th column handshake.
- Post-processing:
  - Lane value -5 with RELU_EN = 1 -> 0.
  - Lane value 70000 -> 32767.
  - With RELU_EN = 0: -70000 -> -32768.
  - SHIFT = 4 with input 0x120 -> 0x12.
- Backpressure: pix_ready toggling 1,0,0,1 during drain -> pix_data, pix_row, pix_col are stable while stalled. No pixel is dropped or duplicated; still exactly 100 handshakes.
- Input bubbles: col_valid low every other cycle -> only 10 valid beats are stored and data matches. col_valid asserted during DRAIN is ignored with col_ready = 0. The buffer is unchanged.
- Reset mid-operation:
  - rst asserted after the 40th pixel -> next cycle state IDLE, pix_valid = 0, busy = 0, no done.
  - A new start then collects and drains a full fresh frame correctly.
- Start handling: start pulsed during COLLECT and DRAIN -> no effect. start held high continuously -> back-to-back frames, with IDLE lasting one cycle between DONE and COLLECT.
